pattern_source: RTL

Parametrised, multi-mode test-pattern generator for the VGA output path. It sits between the timing generator (Vga_controller: Column, Row, inDisplayArea, hsync, vsync) and the DAC/output pins. It produces registered RGB with sync signals delay-matched to it. Modes cover black, solid colour, colour bars, checkerboard, a bouncing box and a top-left block. The active mode and colour change only at frame boundaries.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/pattern_box_mover.sv | 49 ++++
 rtl/pattern_source.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern modes, colour types, default 640x480
// active-area constants and the colour-bar palette helper.
package vga_pkg;

  localparam int VGA_COLOR_W  = 8;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_SOLID = 3'd1,
    MODE_BARS  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_BOX   = 3'd4,
    MODE_BLOCK = 3'd5
  } mode_e;

  typedef struct packed {
    logic [VGA_COLOR_W-1:0] r;
    logic [VGA_COLOR_W-1:0] g;
    logic [VGA_COLOR_W-1:0] b;
  } rgb_t;

  // One bit per channel: channel fully on or fully off.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_mask_t;

  // Bar j (0..7) walks white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_mask_t bar_mask(input logic [2:0] j);
    rgb_mask_t m;
    m.r = ~j[1];
    m.g = ~j[2];
    m.b = ~j[0];
    return m;
  endfunction

endpackage

// File: rtl/pattern_box_mover.sv
// Bouncing-box position: steps one pixel per axis on every frame start and
// reverses direction when an edge of the active area is reached.
module pattern_box_mover
  import vga_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int BOX_SIZE = 64
) (
  input  logic               pxclk,
  input  logic               rst,
  input  logic               step_i,
  output logic [COORD_W-1:0] box_x_o,
  output logic [COORD_W-1:0] box_y_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - BOX_SIZE);

  logic [COORD_W-1:0] box_x_q, box_x_d;
  logic [COORD_W-1:0] box_y_q, box_y_d;
  logic               dx_neg_q, dy_neg_q;

  assign box_x_d = dx_neg_q ? box_x_q - 1'b1 : box_x_q + 1'b1;
  assign box_y_d = dy_neg_q ? box_y_q - 1'b1 : box_y_q + 1'b1;

  // Advance position once per frame; flip direction on reaching either bound.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      box_x_q  <= '0;
      box_y_q  <= '0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
    end else if (step_i) begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      if (box_x_d == X_MAX)   dx_neg_q <= 1'b1;
      else if (box_x_d == '0) dx_neg_q <= 1'b0;
      if (box_y_d == Y_MAX)   dy_neg_q <= 1'b1;
      else if (box_y_d == '0) dy_neg_q <= 1'b0;
    end
  end

  assign box_x_o = box_x_q;
  assign box_y_o = box_y_q;

endmodule

// File: rtl/pattern_source.sv
// Multi-mode VGA test-pattern generator. Registers RGB one cycle after the
// timing generator's coordinates and delays the syncs to match. Mode and
// colour are captured only on the vsync assertion edge.
module pattern_source
  import vga_pkg::*;
#(
  parameter int COLOR_W         = 8,
  parameter int COORD_W         = 10,
  parameter int H_ACTIVE        = VGA_H_ACTIVE,
  parameter int V_ACTIVE        = VGA_V_ACTIVE,
  parameter int BAR_COUNT       = 8,
  parameter int CHECK_SHIFT     = 5,
  parameter int BOX_SIZE        = 64,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                   pxclk,
  input  logic                   rst,
  input  logic [2:0]             mode_i,
  input  logic [3*COLOR_W-1:0]   color_i,
  input  logic [COORD_W-1:0]     column,
  input  logic [COORD_W-1:0]     row,
  input  logic                   in_display,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   frame_start,
  output logic [15:0]            frame_count
);

  localparam logic SYNC_ON  = ~SYNC_ACTIVE_LOW;
  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  localparam int BAR_W = H_ACTIVE / BAR_COUNT;
  localparam int IDX_W = (BAR_COUNT > 1) ? $clog2(BAR_COUNT) : 1;
  localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(BAR_COUNT - 1);

  localparam logic [COORD_W:0] BOX_EXT = (COORD_W+1)'(BOX_SIZE);
  localparam logic [COORD_W:0] BLOCK_W = (COORD_W+1)'(H_ACTIVE / 3);
  localparam logic [COORD_W:0] BLOCK_H = (COORD_W+1)'(V_ACTIVE / 3);

  // Frame-level state
  logic                 hsync_q, vsync_q;
  logic                 frame_start_q, frame_start_d;
  logic [15:0]          frame_cnt_q;
  logic [2:0]           mode_q;
  logic [3*COLOR_W-1:0] color_q;

  // Colour-bar pixel counter and bar index
  logic [COORD_W-1:0]   bar_px_q;
  logic [IDX_W-1:0]     bar_idx_q;
  rgb_mask_t            bar_m;

  // Box position and hit tests
  logic [COORD_W-1:0]   box_x, box_y;
  logic [COORD_W:0]     col_w, row_w, bx_w, by_w;
  logic                 in_box, in_block;

  // Pixel pipeline
  logic [COLOR_W-1:0]   red_q, green_q, blue_q;
  logic [COLOR_W-1:0]   red_d, green_d, blue_d;

  // vsync_q doubles as the delayed output and the edge-detect history.
  assign frame_start_d = (vsync_in == SYNC_ON) && (vsync_q == SYNC_OFF);

  pattern_box_mover #(
    .COORD_W  (COORD_W),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .pxclk   (pxclk),
    .rst     (rst),
    .step_i  (frame_start_d),
    .box_x_o (box_x),
    .box_y_o (box_y)
  );

  // Sync delay line, frame counter and per-frame capture of mode/colour.
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      mode_q        <= MODE_OFF;
      color_q       <= '0;
    end else begin
      hsync_q       <= hsync_in;
      vsync_q       <= vsync_in;
      frame_start_q <= frame_start_d;
      if (frame_start_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        mode_q      <= mode_i;
        color_q     <= color_i;
      end
    end
  end

  // Bar index from a run-length counter over visible pixels, cleared in blanking.
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else if (!in_display) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_q  <= '0;
      bar_idx_q <= (bar_idx_q == IDX_LAST) ? '0 : bar_idx_q + 1'b1;
    end else begin
      bar_px_q  <= bar_px_q + 1'b1;
    end
  end

  assign bar_m = bar_mask(3'(bar_idx_q));

  // Hit tests are one bit wider than the coordinates so box_x+BOX_SIZE cannot wrap.
  assign col_w    = {1'b0, column};
  assign row_w    = {1'b0, row};
  assign bx_w     = {1'b0, box_x};
  assign by_w     = {1'b0, box_y};
  assign in_box   = (col_w >= bx_w) && (col_w < bx_w + BOX_EXT) &&
                    (row_w >= by_w) && (row_w < by_w + BOX_EXT);
  assign in_block = (col_w < BLOCK_W) && (row_w < BLOCK_H);

  // Select the pixel colour for the current coordinate from the latched mode.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (in_display) begin
      case (mode_q)
        MODE_SOLID: {red_d, green_d, blue_d} = color_q;
        MODE_BARS: begin
          red_d   = {COLOR_W{bar_m.r}};
          green_d = {COLOR_W{bar_m.g}};
          blue_d  = {COLOR_W{bar_m.b}};
        end
        MODE_CHECK: if (column[CHECK_SHIFT] ^ row[CHECK_SHIFT]) {red_d, green_d, blue_d} = '1;
        MODE_BOX:   if (in_box)   {red_d, green_d, blue_d} = color_q;
        MODE_BLOCK: if (in_block) {red_d, green_d, blue_d} = color_q;
        default: ;
      endcase
    end
  end

  // Output pixel register: one cycle of latency in every mode.
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_cnt_q;

endmodule
